// File: rtl/imm_pkg.sv
// Shared encodings for the decode stage: ImmSel codes and the RV32I opcodes that select them.
package imm_pkg;

    localparam logic [3:0] IMM_I    = 4'b0000;
    localparam logic [3:0] IMM_S    = 4'b0001;
    localparam logic [3:0] IMM_B    = 4'b0010;
    localparam logic [3:0] IMM_J    = 4'b0100;
    localparam logic [3:0] IMM_U    = 4'b1000;
    localparam logic [3:0] IMM_NONE = 4'b1100;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: formats instr[31:7] into a 32-bit immediate according to ImmSel.
module imm_gen
    import imm_pkg::*;
(
    input  logic [24:0] instr_i,
    input  logic [3:0]  imm_sel_i,
    output logic [31:0] imm_o
);

    // instr_i[k] carries instruction bit k+7
    always_comb begin
        imm_o = '0;
        case (imm_sel_i)
            IMM_I: imm_o = {{20{instr_i[24]}}, instr_i[24:13]};
            IMM_S: imm_o = {{20{instr_i[24]}}, instr_i[24:18], instr_i[4:0]};
            IMM_B: imm_o = {{20{instr_i[24]}}, instr_i[0], instr_i[23:18], instr_i[4:1], 1'b0};
            IMM_J: imm_o = {{12{instr_i[24]}}, instr_i[12:5], instr_i[13], instr_i[23:14], 1'b0};
            IMM_U: imm_o = {instr_i[24:5], 12'h000};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_sel_decode.sv
// Combinational opcode decode into ImmSel plus branch/jal/illegal flags.
module imm_sel_decode
    import imm_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [3:0] imm_sel_o,
    output logic       is_branch_o,
    output logic       is_jal_o,
    output logic       illegal_o
);

    always_comb begin
        imm_sel_o   = IMM_NONE;
        is_branch_o = 1'b0;
        is_jal_o    = 1'b0;
        illegal_o   = 1'b0;
        case (opcode_i)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: imm_sel_o = IMM_I;
            OPC_STORE:                                  imm_sel_o = IMM_S;
            OPC_BRANCH: begin
                imm_sel_o   = IMM_B;
                is_branch_o = 1'b1;
            end
            OPC_JAL: begin
                imm_sel_o = IMM_J;
                is_jal_o  = 1'b1;
            end
            OPC_LUI, OPC_AUIPC:                         imm_sel_o = IMM_U;
            OPC_OP:                                     imm_sel_o = IMM_NONE;
            default:                                    illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Decode stage: opcode decode, immediate generation, early PC+imm target and the ID/EX register
// behind a valid/ready handshake with flush.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_flush,
    input  logic            i_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_imm,
    output logic [3:0]      o_imm_sel,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_target,
    output logic            o_is_branch,
    output logic            o_is_jal,
    output logic            o_illegal
);

    logic [3:0]      dec_sel;
    logic            dec_branch, dec_jal, dec_illegal;
    logic [XLEN-1:0] gen_imm;
    logic [XLEN-1:0] gen_target;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] imm_q, imm_d, pc_q, pc_d, target_q, target_d;
    logic [3:0]      sel_q, sel_d;
    logic            branch_q, branch_d, jal_q, jal_d, illegal_q, illegal_d;
    logic            accept, drain;

    imm_sel_decode u_dec (
        .opcode_i    (i_instr[6:0]),
        .imm_sel_o   (dec_sel),
        .is_branch_o (dec_branch),
        .is_jal_o    (dec_jal),
        .illegal_o   (dec_illegal)
    );

    imm_gen u_gen (
        .instr_i   (i_instr[31:7]),
        .imm_sel_i (dec_sel),
        .imm_o     (gen_imm)
    );

    assign gen_target = i_pc + gen_imm;

    // ready looks only at downstream and the held entry, never at i_valid
    assign o_ready = !valid_q || i_ready;
    assign accept  = i_valid && o_ready;
    assign drain   = valid_q && i_ready;

    always_comb begin
        valid_d   = valid_q;
        imm_d     = imm_q;
        sel_d     = sel_q;
        pc_d      = pc_q;
        target_d  = target_q;
        branch_d  = branch_q;
        jal_d     = jal_q;
        illegal_d = illegal_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            imm_d     = gen_imm;
            sel_d     = dec_sel;
            pc_d      = i_pc;
            target_d  = gen_target;
            branch_d  = dec_branch;
            jal_d     = dec_jal;
            illegal_d = dec_illegal;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q   <= 1'b0;
            imm_q     <= '0;
            sel_q     <= IMM_NONE;
            pc_q      <= '0;
            target_q  <= '0;
            branch_q  <= 1'b0;
            jal_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            imm_q     <= imm_d;
            sel_q     <= sel_d;
            pc_q      <= pc_d;
            target_q  <= target_d;
            branch_q  <= branch_d;
            jal_q     <= jal_d;
            illegal_q <= illegal_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_imm       = imm_q;
    assign o_imm_sel   = sel_q;
    assign o_pc        = pc_q;
    assign o_target    = target_q;
    assign o_is_branch = branch_q;
    assign o_is_jal    = jal_q;
    assign o_illegal   = illegal_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Randomized and directed checks of imm_decode_stage against a behavioural model of the stage.
module tb_imm_decode_stage;

    logic        i_clk = 1'b0;
    logic        i_reset, i_valid, i_flush, i_ready;
    logic [31:0] i_instr, i_pc;
    logic        o_ready, o_valid, o_is_branch, o_is_jal, o_illegal;
    logic [31:0] o_imm, o_pc, o_target;
    logic [3:0]  o_imm_sel;

    int n_checks = 0;
    int n_fail   = 0;

    // model of the held entry
    logic        m_valid;
    logic [31:0] m_imm, m_pc, m_target;
    logic [3:0]  m_sel;
    logic        m_br, m_jal, m_ill;

    imm_decode_stage #(.XLEN(32)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_instr     (i_instr),
        .i_pc        (i_pc),
        .i_flush     (i_flush),
        .i_ready     (i_ready),
        .o_valid     (o_valid),
        .o_imm       (o_imm),
        .o_imm_sel   (o_imm_sel),
        .o_pc        (o_pc),
        .o_target    (o_target),
        .o_is_branch (o_is_branch),
        .o_is_jal    (o_is_jal),
        .o_illegal   (o_illegal)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // opcode table from the instruction-set listing: {sel, branch, jal, illegal}
    function automatic logic [6:0] ref_dec(input logic [6:0] opc);
        case (opc)
            7'h03, 7'h13, 7'h67, 7'h73: return {4'b0000, 3'b000};
            7'h23:                      return {4'b0001, 3'b000};
            7'h63:                      return {4'b0010, 3'b100};
            7'h6F:                      return {4'b0100, 3'b010};
            7'h37, 7'h17:               return {4'b1000, 3'b000};
            7'h33:                      return {4'b1100, 3'b000};
            default:                    return {4'b1100, 3'b001};
        endcase
    endfunction

    // immediates built arithmetically with shifts and masks from the whole instruction word
    function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [3:0] sel);
        logic signed [31:0] s;
        logic [31:0] sgn;
        s   = ins;
        sgn = s >>> 31;
        case (sel)
            4'b0000: return s >>> 20;
            4'b0001: return (sgn << 12) | (((ins >> 25) & 32'h7F) << 5) | ((ins >> 7) & 32'h1F);
            4'b0010: return (sgn << 12) | (((ins >> 7) & 32'h1) << 11)
                            | (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
            4'b0100: return (sgn << 20) | (((ins >> 12) & 32'hFF) << 12)
                            | (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
            4'b1000: return ins & 32'hFFFF_F000;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_imm = 0; m_sel = 4'b1100; m_pc = 0; m_target = 0;
        m_br = 0; m_jal = 0; m_ill = 0;
    endtask

    // one clock: drive inputs, check ready, advance model, check registered outputs
    task automatic step(input logic rst, input logic vld, input logic [31:0] ins,
                        input logic [31:0] pc, input logic rdy, input logic fl);
        logic [6:0] d;
        logic       acc;
        i_reset = rst; i_valid = vld; i_instr = ins; i_pc = pc; i_ready = rdy; i_flush = fl;
        #1;
        chk("o_ready", {31'b0, o_ready}, {31'b0, (!m_valid || rdy)});
        acc = vld && (!m_valid || rdy);
        d   = ref_dec(ins[6:0]);
        if (rst) model_reset();
        else if (fl) m_valid = 0;
        else if (acc) begin
            m_valid = 1; m_sel = d[6:3]; m_imm = ref_imm(ins, d[6:3]);
            m_pc = pc; m_target = pc + m_imm; m_br = d[2]; m_jal = d[1]; m_ill = d[0];
        end else if (m_valid && rdy) m_valid = 0;
        @(posedge i_clk);
        #1;
        chk("o_valid", {31'b0, o_valid}, {31'b0, m_valid});
        if (m_valid) begin
            chk("o_imm", o_imm, m_imm);
            chk("o_imm_sel", {28'b0, o_imm_sel}, {28'b0, m_sel});
            chk("o_pc", o_pc, m_pc);
            chk("o_target", o_target, m_target);
            chk("o_flags", {29'b0, o_is_branch, o_is_jal, o_illegal}, {29'b0, m_br, m_jal, m_ill});
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_valid"}, {31'b0, o_valid}, 32'h0);
        chk({tag, "_imm"}, o_imm, 32'h0);
        chk({tag, "_sel"}, {28'b0, o_imm_sel}, 32'hC);
        chk({tag, "_pc"}, o_pc, 32'h0);
        chk({tag, "_target"}, o_target, 32'h0);
        chk({tag, "_flags"}, {29'b0, o_is_branch, o_is_jal, o_illegal}, 32'h0);
    endtask

    logic [6:0] opc_tab [11] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
                                 7'h6F, 7'h37, 7'h17, 7'h33, 7'h7F};

    initial begin
        logic [31:0] r;
        logic [6:0]  opc;
        model_reset();
        i_reset = 1; i_valid = 0; i_instr = 0; i_pc = 0; i_ready = 0; i_flush = 0;
        @(posedge i_clk); #1;
        step(1, 0, 0, 0, 1, 0);
        chk_reset_values("rst");

        // addi x1,x0,-1
        step(0, 1, 32'hFFF00093, 32'h100, 1, 0);
        chk("t1_valid", {31'b0, o_valid}, 32'h1);
        chk("t1_imm", o_imm, 32'hFFFF_FFFF);
        chk("t1_sel", {28'b0, o_imm_sel}, 32'h0);
        // beq x0,x0,-4
        step(0, 1, 32'hFE000EE3, 32'h200, 1, 0);
        chk("t2_imm", o_imm, 32'hFFFF_FFFC);
        chk("t2_target", o_target, 32'h1FC);
        chk("t2_branch", {31'b0, o_is_branch}, 32'h1);
        // jal x0,8 with PC wrap
        step(0, 1, 32'h0080006F, 32'hFFFF_FFFC, 1, 0);
        chk("t3_imm", o_imm, 32'h8);
        chk("t3_target", o_target, 32'h4);
        chk("t3_jal", {31'b0, o_is_jal}, 32'h1);
        // lui then sw back-to-back
        step(0, 1, 32'h123452B7, 32'h300, 1, 0);
        chk("t4_lui_imm", o_imm, 32'h1234_5000);
        step(0, 1, 32'h0020A623, 32'h304, 1, 0);
        chk("t4_sw_imm", o_imm, 32'h0000_000C);
        chk("t4_sw_valid", {31'b0, o_valid}, 32'h1);
        // stall: hold lui while downstream is blocked
        step(0, 1, 32'h123452B7, 32'h400, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 32'h0020A623, 32'h404, 0, 0);
            chk("t5_stall_imm", o_imm, 32'h1234_5000);
            chk("t5_stall_pc", o_pc, 32'h400);
        end
        i_ready = 0; #1;
        chk("t5_ready_low", {31'b0, o_ready}, 32'h0);
        step(0, 1, 32'h0020A623, 32'h404, 1, 0);
        chk("t5_drain_accept", o_imm, 32'h0000_000C);
        chk("t5_drain_pc", o_pc, 32'h404);
        // flush kills held entry and the accept
        step(0, 1, 32'hFFF00093, 32'h500, 1, 1);
        chk("t6_flush_valid", {31'b0, o_valid}, 32'h0);
        // flush with nothing going on
        step(0, 0, 32'h0, 32'h0, 1, 1);
        chk("t6_flush_idle", {31'b0, o_valid}, 32'h0);
        // illegal opcode
        step(0, 1, 32'hFFFF_FFFF, 32'h600, 1, 0);
        chk("t6_illegal", {31'b0, o_illegal}, 32'h1);
        chk("t6_illegal_imm", o_imm, 32'h0);
        // reset during stall
        step(0, 1, 32'h0080006F, 32'h700, 0, 0);
        step(0, 1, 32'hFE000EE3, 32'h704, 0, 0);
        step(1, 1, 32'hFE000EE3, 32'h704, 0, 0);
        chk_reset_values("t6_rst");

        for (int n = 0; n < 3000; n++) begin
            r   = $urandom;
            opc = ($urandom_range(0, 4) == 0) ? 7'($urandom) : opc_tab[$urandom_range(0, 10)];
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), {r[31:7], opc},
                 $urandom, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
